mode1_ctrl: RTL and testbench
=============================

// Module: mode1_ctrl
// PURPOSE
//  Sequencer for the mode-1 max-reduction tree (8-lane compare tree, 2-cycle latency).
//  On start: clears the tree's running max, then streams NUM_WORDS 8-lane words from input memory.
//  Asserts the tree's run enable exactly in the cycles when memory read data is valid.
//  Waits for the tree pipeline to drain, then pulses done; the tree output then holds the global max.
// PARAMETERS
//  ADDRWIDTH  8  width of the input-memory word address
//  LENWIDTH   8  width of the word-count input
//  MEM_LAT    1  memory read latency in cycles (rd_en to data valid); legal range 1..4
//  TREE_LAT   2  cycles from the last run-enable cycle to the tree output becoming valid; legal range 1..4
// PORTS
//  clk             in   1          clock, rising edge
//  reset           in   1          asynchronous, active-low reset
//  start           in   1          1-cycle request; sampled only in IDLE
//  start_addr      in   ADDRWIDTH  first word address; sampled with start
//  num_words       in   LENWIDTH   number of words to reduce; sampled with start
//  pause           in   1          stalls read issue while high (READ state only)
//  mem_rd_en       out  1          memory read strobe
//  mem_rd_addr     out  ADDRWIDTH  memory read address
//  mode1_run       out  1          tree run enable, aligned to read-data-valid
//  max_tree_reset  out  1          1-cycle synchronous active-high clear to the tree
//  busy            out  1          high in every state except IDLE
//  done            out  1          1-cycle pulse; the tree output is valid in this cycle
// BEHAVIOUR
//  Reset
//   - Asynchronous assertion on reset==0: every output is 0 and the FSM is in IDLE.
//   - The delay line and all counters clear.
//   - Reset mid-operation abandons the job; no done is produced.
//  Output timing
//   - All outputs are registered.
//   - "Cycle k" means the cycle after the k-th rising edge following the start sample (cycle 0).
//  FSM: IDLE -> CLEAR -> READ -> DRAIN -> DONE -> IDLE
//   - IDLE:
//     - start=1 and num_words>0: latch addr/count, go to CLEAR.
//     - start=1 and num_words==0: go straight to DONE; no reads and no clear.
//   - CLEAR (1 cycle): max_tree_reset=1, then go to READ.
//   - READ:
//     - Each cycle with pause=0: mem_rd_en=1 at the current address, address+1, remaining-1.
//     - pause=1: mem_rd_en=0; address and count hold.
//     - After the cycle that issues the final read, go to DRAIN.
//   - DRAIN: wait MEM_LAT+TREE_LAT-1 cycles, then go to DONE.
//   - DONE (1 cycle): done=1, busy=1, then go to IDLE.
//  Alignment and ordering rules
//   - mode1_run = mem_rd_en delayed exactly MEM_LAT cycles through a shift register.
//   - Pause gaps propagate as gaps in mode1_run; the tree tolerates gaps.
//   - done falls exactly MEM_LAT+TREE_LAT cycles after the cycle of the last mem_rd_en.
//  Boundary conditions
//   - Address arithmetic is modulo 2^ADDRWIDTH; 0xFF+1 wraps to 0x00 with no error.
//   - start while busy is ignored; it is not queued.
//   - start in the DONE cycle is ignored.
//   - start in the cycle after DONE (back in IDLE) is accepted.
//   - pause outside READ has no effect.
//   - num_words = 2^LENWIDTH-1 is legal; the count is never wider than LENWIDTH.
// TESTING
//  T1 basic:
//   - Stimulus: start@c0, start_addr=0x10, num_words=4, MEM_LAT=1, TREE_LAT=2, pause=0.
//   - max_tree_reset@c1; mem_rd_en c2..c5 with addr 0x10..0x13; mode1_run c3..c6; done@c8.
//   - Tree lanes hold {1.0, -3.5, 7.25, 2.0, ...}; tree output = 7.25 at c8.
//  T2 pause:
//   - Stimulus: as T1, but pause=1 in c3..c4.
//   - Required: reads at c2, c5, c6, c7; addresses contiguous 0x10..0x13; mode1_run c3, c6..c8; done@c10.
//  T3 zero length:
//   - Stimulus: num_words=0.
//   - Required: no mem_rd_en, no max_tree_reset, done@c1.
//   - Tree output unchanged.
//  T4 wrap and ignored start:
//   - Stimulus: start_addr=0xFE, num_words=3.
//   - Required: addresses 0xFE, 0xFF, 0x00.
//   - Second start pulse at c3 ignored: exactly 3 reads, then one done.
//  T5 reset mid-run:
//   - Stimulus: reset low at c3 of T1.
//   - Required: all outputs 0 immediately (async); no done.
//   - A new start after release runs T1 timing again.
//  T6 latency sweep:
//   - Stimulus: MEM_LAT=3, TREE_LAT=2, num_words=2.
//   - Required: reads c2..c3; mode1_run c5..c6; done@c8.

Source files
------------

// File: rtl/mode1_ctrl.sv
// Sequencer for the mode-1 max-reduction tree: clears the tree, streams words
// from input memory with a read-aligned run enable, drains the tree and pulses done.
module mode1_ctrl #(
    parameter int ADDRWIDTH = 8,
    parameter int LENWIDTH  = 8,
    parameter int MEM_LAT   = 1,
    parameter int TREE_LAT  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDRWIDTH-1:0] start_addr,
    input  logic [LENWIDTH-1:0]  num_words,
    input  logic                 pause,
    output logic                 mem_rd_en,
    output logic [ADDRWIDTH-1:0] mem_rd_addr,
    output logic                 mode1_run,
    output logic                 max_tree_reset,
    output logic                 busy,
    output logic                 done
);

    localparam int DRAIN_CYC = MEM_LAT + TREE_LAT - 1;
    localparam int DW        = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               state, state_n;
    logic [ADDRWIDTH-1:0] addr_q;
    logic [LENWIDTH-1:0]  remaining;
    logic [DW-1:0]        drain_cnt;
    logic [MEM_LAT-1:0]   rd_pipe;
    logic                 issue;

    // Pause must gate the read in the same cycle it is raised, so the strobe
    // is decoded from the state register and pause rather than registered.
    assign issue       = (state == S_READ) && !pause;
    assign mem_rd_en   = issue;
    assign mem_rd_addr = addr_q;
    assign mode1_run   = rd_pipe[MEM_LAT-1];

    always_comb begin
        // NOTE: default first so every path assigns state_n and no latch is inferred.
        state_n = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = (num_words != '0) ? S_CLEAR : S_DONE;
                end
            end
            S_CLEAR: state_n = S_READ;
            S_READ: begin
                if (issue && remaining == LENWIDTH'(1)) begin
                    state_n = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_cnt == DW'(DRAIN_CYC - 1)) begin
                    state_n = S_DONE;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: non-blocking assignments for all sequential state so every
            // flop samples pre-edge values regardless of statement order.
            state          <= S_IDLE;
            addr_q         <= '0;
            remaining      <= '0;
            drain_cnt      <= '0;
            rd_pipe        <= '0;
            max_tree_reset <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            state <= state_n;

            if (state == S_IDLE && start && num_words != '0) begin
                addr_q    <= start_addr;
                remaining <= num_words;
            end else if (issue) begin
                addr_q    <= addr_q + ADDRWIDTH'(1);
                remaining <= remaining - LENWIDTH'(1);
            end

            if (state == S_DRAIN) begin
                drain_cnt <= drain_cnt + DW'(1);
            end else begin
                drain_cnt <= '0;
            end

            // Run enable is the read strobe delayed by the memory latency.
            rd_pipe <= (rd_pipe << 1) | MEM_LAT'(issue);

            max_tree_reset <= (state_n == S_CLEAR);
            busy           <= (state_n != S_IDLE);
            done           <= (state_n == S_DONE);
        end
    end

endmodule

// File: tb/tb_mode1_ctrl.sv
// Directed bench for mode1_ctrl: cycle-by-cycle checks of the read, run, clear,
// busy and done timing, plus a small tree model that folds read-aligned data.
module tb_mode1_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] start_addr = '0;
    logic [7:0] num_words = '0;
    logic       pause = 1'b0;

    logic       rd, clr, run, busy, done;
    logic [7:0] addr;
    logic       rd3, clr3, run3, busy3, done3;
    logic [7:0] addr3;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    mode1_ctrl #(.ADDRWIDTH(8), .LENWIDTH(8), .MEM_LAT(1), .TREE_LAT(2)) dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
        .num_words(num_words), .pause(pause), .mem_rd_en(rd), .mem_rd_addr(addr),
        .mode1_run(run), .max_tree_reset(clr), .busy(busy), .done(done)
    );

    mode1_ctrl #(.ADDRWIDTH(8), .LENWIDTH(8), .MEM_LAT(3), .TREE_LAT(2)) dut3 (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
        .num_words(num_words), .pause(pause), .mem_rd_en(rd3), .mem_rd_addr(addr3),
        .mode1_run(run3), .max_tree_reset(clr3), .busy(busy3), .done(done3)
    );

    // Tree model for the MEM_LAT=1 instance, values in quarter units:
    // words 0x10..0x13 hold 1.0, -3.5, 7.25, 2.0.
    int         tree_max = 0;
    logic [7:0] addr_d1 = '0;

    function automatic int word_val(input logic [7:0] a);
        case (a)
            8'h10:   return 4;
            8'h11:   return -14;
            8'h12:   return 29;
            8'h13:   return 8;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk) begin
        addr_d1 <= addr;
        if (clr) begin
            tree_max <= -1000;
        end else if (run && word_val(addr_d1) > tree_max) begin
            tree_max <= word_val(addr_d1);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One job: start in cycle 0, then check cycles 1..ncyc against bit masks
    // indexed by cycle number.
    task automatic run_job(input string tag, input bit lat3,
                           input logic [7:0] sa, input logic [7:0] nw,
                           input logic [31:0] smask, input logic [31:0] pmask,
                           input logic [31:0] e_rd, input logic [31:0] e_run,
                           input logic [31:0] e_clr, input int done_cyc, input int ncyc);
        int         idx = 0;
        logic [7:0] ea;
        @(posedge clk); #1;
        start = 1'b1; start_addr = sa; num_words = nw; pause = pmask[0];
        #1;
        chk($sformatf("%s c0 busy", tag), 32'(lat3 ? busy3 : busy), 32'd0);
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clk); #1;
            start = smask[k]; pause = pmask[k];
            #1;
            chk($sformatf("%s c%0d rd", tag, k),   32'(lat3 ? rd3 : rd),     32'(e_rd[k]));
            chk($sformatf("%s c%0d run", tag, k),  32'(lat3 ? run3 : run),   32'(e_run[k]));
            chk($sformatf("%s c%0d clr", tag, k),  32'(lat3 ? clr3 : clr),   32'(e_clr[k]));
            chk($sformatf("%s c%0d done", tag, k), 32'(lat3 ? done3 : done), 32'(k == done_cyc));
            chk($sformatf("%s c%0d busy", tag, k), 32'(lat3 ? busy3 : busy), 32'(k <= done_cyc));
            if (e_rd[k]) begin
                ea = sa + 8'(idx);
                chk($sformatf("%s c%0d addr", tag, k), 32'(lat3 ? addr3 : addr), 32'(ea));
                idx++;
            end
        end
        start = 1'b0; pause = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst rd", 32'(rd), 32'd0);
        chk("rst addr", 32'(addr), 32'd0);
        chk("rst run", 32'(run), 32'd0);
        chk("rst clr", 32'(clr), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // T1 basic
        run_job("T1", 1'b0, 8'h10, 8'd4, 32'h1, 32'h0,
                32'h3C, 32'h78, 32'h2, 8, 8);
        chk("T1 tree", 32'(tree_max), 32'(29));

        // T2 pause, started in the cycle right after T1's done
        run_job("T2", 1'b0, 8'h10, 8'd4, 32'h1, 32'h18,
                32'hE4, 32'h1C8, 32'h2, 10, 10);
        chk("T2 tree", 32'(tree_max), 32'(29));

        // T3 zero length: no reads, no clear, tree untouched
        run_job("T3", 1'b0, 8'h10, 8'd0, 32'h1, 32'h0,
                32'h0, 32'h0, 32'h0, 1, 3);
        chk("T3 tree", 32'(tree_max), 32'(29));

        // T4 wrap; starts at c3 (READ) and c7 (DONE) ignored; pause in CLEAR/DRAIN ignored
        run_job("T4", 1'b0, 8'hFE, 8'd3, 32'h89, 32'h22,
                32'h1C, 32'h38, 32'h2, 7, 11);

        // T5 reset mid-run
        @(posedge clk); #1;
        start = 1'b1; start_addr = 8'h10; num_words = 8'd4;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        chk("T5 c3 rd before reset", 32'(rd), 32'd1);
        reset = 1'b0;
        #1;
        chk("T5 async rd", 32'(rd), 32'd0);
        chk("T5 async addr", 32'(addr), 32'd0);
        chk("T5 async run", 32'(run), 32'd0);
        chk("T5 async clr", 32'(clr), 32'd0);
        chk("T5 async busy", 32'(busy), 32'd0);
        chk("T5 async done", 32'(done), 32'd0);
        chk("T5 async busy3", 32'(busy3), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #2;
            chk($sformatf("T5 held %0d done", i), 32'(done), 32'd0);
        end
        reset = 1'b1;
        run_job("T5 rerun", 1'b0, 8'h10, 8'd4, 32'h1, 32'h0,
                32'h3C, 32'h78, 32'h2, 8, 12);
        chk("T5 tree", 32'(tree_max), 32'(29));

        // T6 latency sweep on the MEM_LAT=3 instance
        run_job("T6", 1'b1, 8'h20, 8'd2, 32'h1, 32'h0,
                32'h0C, 32'h60, 32'h2, 8, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
